// File: rtl/clk_div_multi_if.sv
// Divisor write bus for clk_div_multi.
//   wr_en  : write strobe, one write per asserted cycle
//   wr_ch  : target channel (values >= NCH are dropped by the divider)
//   wr_div : new half-period divisor in clk cycles
// master drives the bus, slave (the divider) receives it.
interface clk_div_multi_if #(
  parameter int CHW = 2,
  parameter int W   = 16
);
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [W-1:0]   wr_div;

  modport master (output wr_en, wr_ch, wr_div);
  modport slave  (input  wr_en, wr_ch, wr_div);
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider, 50% duty.
// Each channel holds an active divisor D, a shadow S and a counter; the output
// toggles every D cycles. New divisors land in S and move to D only at terminal
// count (or immediately while stopped), so a running output never glitches.
//
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high
//   en      : [NCH] per-channel run enable
//   wr      : divisor write bus (clk_div_multi_if.slave)
//   sync    : global phase realign; only acts when CLK_DIV_MULTI_SYNC_EN is defined
//   clk_out : [NCH] divided clocks (registered)
//   tick    : [NCH] one-cycle pulse coincident with each clk_out rise
//
// Build option: define CLK_DIV_MULTI_SYNC_EN to compile in the sync feature.

module clk_div_chan #(
  parameter int           W       = 16,
  parameter logic [W-1:0] DEF_DIV = W'(50000)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sync_act,
  input  logic         wr_hit,
  input  logic [W-1:0] wr_div,
  output logic         clk_out,
  output logic         tick
);
  logic [W-1:0] cnt, d, s, s_nxt;
  logic         tc;

  // A write always lands in the shadow; the same value is what D picks up
  // whenever D is allowed to reload this cycle, so same-cycle writes win.
  assign s_nxt = wr_hit ? wr_div : s;
  assign tc    = (cnt == d - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      d       <= DEF_DIV;
      s       <= DEF_DIV;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      s <= s_nxt;
      if (sync_act || !en || d == '0) begin
        // stopped or realigning: hold cleared, keep D tracking S
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        d       <= s_nxt;
      end else if (tc) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;   // pulse only on the 0->1 toggle
        d       <= s_nxt;
      end else begin
        cnt     <= cnt + 1'b1;
        tick    <= 1'b0;
      end
    end
  end
endmodule

module clk_div_multi #(
  parameter int           NCH     = 4,
  parameter int           W       = 16,
  parameter int           CHW     = 2,
  parameter logic [W-1:0] DEF_DIV = W'(50000)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      en,
  clk_div_multi_if.slave      wr,
  input  logic                sync,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      tick
);
  logic sync_act;

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign sync_act = sync;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign sync_act    = 1'b0;
`endif

  // Out-of-range wr_ch matches no channel index, so such writes fall away.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_hit;
    assign wr_hit = wr.wr_en && (wr.wr_ch == CHW'(i));

    clk_div_chan #(.W(W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (en[i]),
      .sync_act (sync_act),
      .wr_hit   (wr_hit),
      .wr_div   (wr.wr_div),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi (NCH=3 so wr_ch=3 is out of range,
// DEF_DIV=3). The reference model tracks, per channel, the number of cycles
// left until the next output toggle rather than an up-counter.
module tb_clk_div_multi;
  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sync = 1'b0;
  logic [NCH-1:0] en = '0;
  logic [NCH-1:0] clk_out, tick;

  clk_div_multi_if #(.CHW(CHW), .W(W)) wr ();

  clk_div_multi #(.NCH(NCH), .W(W), .CHW(CHW), .DEF_DIV(8'd3)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .wr      (wr),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  int md  [NCH];   // active divisor
  int ms  [NCH];   // shadow divisor
  int rem [NCH];   // cycles left until the next toggle
  bit lvl [NCH];
  bit mtk [NCH];

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      md[i] = 3; ms[i] = 3; rem[i] = 3; lvl[i] = 0; mtk[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit sy;
`ifdef CLK_DIV_MULTI_SYNC_EN
    sy = sync;
`else
    sy = 1'b0;
`endif
    for (int i = 0; i < NCH; i++) begin
      int ns;
      ns = (wr.wr_en && int'(wr.wr_ch) == i) ? int'(wr.wr_div) : ms[i];
      if (sy || !en[i] || md[i] == 0) begin
        lvl[i] = 0; mtk[i] = 0; md[i] = ns; rem[i] = ns;
      end else begin
        rem[i]--;
        mtk[i] = 0;
        if (rem[i] == 0) begin
          mtk[i] = !lvl[i];
          lvl[i] = !lvl[i];
          md[i]  = ns;
          rem[i] = ns;
        end
      end
      ms[i] = ns;
    end
  endtask

  function automatic int model_vec();
    int v = 0;
    for (int i = 0; i < NCH; i++) begin
      v[NCH+i] = lvl[i];
      v[i]     = mtk[i];
    end
    return v;
  endfunction

  // one clock: model advances with the DUT, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("outputs", int'({clk_out, tick}), model_vec());
  endtask

  task automatic write(int ch, int div);
    wr.wr_en  = 1'b1;
    wr.wr_ch  = CHW'(ch);
    wr.wr_div = W'(div);
  endtask

  initial begin
    int ntick, n, mask, n0, n1;
    bit prev;
    model_reset();
    wr.wr_en = 1'b0; wr.wr_ch = '0; wr.wr_div = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", int'({clk_out, tick}), 0);

    // default divisor 3 on channel 0: rises at edges 3 and 9 of 12
    reset = 1'b0;
    en = 3'b001;
    ntick = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      ntick += int'(tick[0]);
    end
    chk("div3_ticks", ntick, 2);

    // D=4 then rewrite to 2 while cnt=1: half-periods 4,2,2
    en = 3'b000;
    write(0, 4);
    step();
    wr.wr_en = 1'b0;
    en = 3'b001;
    mask = 0;
    prev = clk_out[0];
    for (int k = 1; k <= 8; k++) begin
      step();
      if (clk_out[0] != prev) mask |= (1 << k);
      prev = clk_out[0];
      if (k == 1) write(0, 2);
      if (k == 2) wr.wr_en = 1'b0;
    end
    chk("no_runt_toggles", mask, 'h150);

    // divisor 0 stops channel 1 at terminal count; 5 restarts it
    en = 3'b011;
    repeat (4) step();
    write(1, 0);
    step();
    wr.wr_en = 1'b0;
    repeat (8) step();
    ntick = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      ntick += int'(tick[1]);
    end
    chk("stop_tick", ntick, 0);
    chk("stop_out", int'(clk_out[1]), 0);
    write(1, 5);
    step();
    wr.wr_en = 1'b0;
    n = 0;
    while (!clk_out[1] && n < 20) begin step(); n++; end
    chk("restart5", n, 5);

    // drop en[2] while high, then re-enable: first toggle (a rise) after D
    en = 3'b111;
    n = 0;
    while (!clk_out[2] && n < 20) begin step(); n++; end
    chk("ch2_high", int'(clk_out[2]), 1);
    en[2] = 1'b0;
    step();
    chk("ch2_drop", int'(clk_out[2]), 0);
    en[2] = 1'b1;
    n = 0;
    while (!clk_out[2] && n < 20) begin step(); n++; end
    chk("ch2_rise", n, 3);

    // out-of-range channel write must change nothing
    write(3, 1);
    step();
    wr.wr_en = 1'b0;
    repeat (12) step();

`ifdef CLK_DIV_MULTI_SYNC_EN
    en = 3'b011;
    write(0, 3); step();
    write(1, 5); step();
    wr.wr_en = 1'b0;
    repeat (13) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_clr", int'(clk_out), 0);
    n0 = 0; n1 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (clk_out[0] && n0 == 0) n0 = k;
      if (clk_out[1] && n1 == 0) n1 = k;
    end
    chk("sync_rise_d3", n0, 3);
    chk("sync_rise_d5", n1, 5);
`else
    n0 = 0; n1 = 0;
`endif

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      wr.wr_en  = ($urandom_range(3) == 0);
      wr.wr_ch  = CHW'($urandom_range(3));
      wr.wr_div = W'($urandom_range(6));
      if ($urandom_range(15) == 0) en[$urandom_range(NCH-1)] ^= 1'b1;
      sync = ($urandom_range(31) == 0);
      step();
    end
    wr.wr_en = 1'b0;
    sync = 1'b0;

    // asynchronous reset between edges clears outputs before the next edge
    en = 3'b111;
    @(posedge clk);
    model_edge();
    #2 reset = 1'b1;
    model_reset();
    #1 chk("async_rst", int'({clk_out, tick}), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
